// File: rtl/pixel_stream_pkg.sv
// Shared types for the pixel stream tagger slice.
// Holds the default pixel width, the tagged-beat layout {data, eol, tlast},
// the tagger FSM state encoding and a constant-evaluable clog2 helper.
package pixel_stream_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  // Tagged beat as stored by the core's output FIFO, at the default width.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic                      eol;
    logic                      tlast;
  } beat_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Generic 2-entry valid/ready register slice (main + skid), full throughput.
// Latency: 1 cycle up_dat -> dn_dat; up_rdy is a registered (~skid full) term.
// Backpressure: a stalled downstream parks one extra beat in skid, then up_rdy drops.
// Ports: clk, rst_n (sync, active-low); up_vld/up_rdy/up_dat upstream;
//        dn_vld/dn_rdy/dn_dat downstream; skid_full occupancy flag.
module stream_skid_buffer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_vld,
  output logic             up_rdy,
  input  logic [WIDTH-1:0] up_dat,
  output logic             dn_vld,
  input  logic             dn_rdy,
  output logic [WIDTH-1:0] dn_dat,
  output logic             skid_full
);

  logic             main_vld;
  logic             skid_vld;
  logic [WIDTH-1:0] main_dat;
  logic [WIDTH-1:0] skid_dat;
  logic             up_hs;
  logic             dn_hs;

  // Ready depends only on registered skid state; held low throughout reset.
  assign up_rdy    = rst_n & ~skid_vld;
  assign up_hs     = up_vld & up_rdy;
  assign dn_hs     = main_vld & dn_rdy;
  assign dn_vld    = main_vld;
  assign dn_dat    = main_dat;
  assign skid_full = skid_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_dat <= '0;
      skid_dat <= '0;
    end else if (dn_hs) begin
      // Skid holds the older beat, so it always wins the refill of main.
      // up_hs cannot coincide with a full skid since up_rdy is low then.
      if (skid_vld) begin
        main_dat <= skid_dat;
        skid_vld <= 1'b0;
      end else if (up_hs) begin
        main_dat <= up_dat;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (up_hs) begin
      if (main_vld) begin
        skid_dat <= up_dat;
        skid_vld <= 1'b1;
      end else begin
        main_dat <= up_dat;
        main_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_stream_tagger.sv
// Pixel stream front end: counts col/row and tags each pixel with EOL and frame tlast.
// Latency: 1 cycle s_data -> m_data through a 2-entry skid buffer, 1 beat/clk sustained.
// Backpressure: m_ready low fills main then skid; s_ready drops only when skid is full.
// Ports: clk, rst_n (sync, active-low); s_valid/s_ready/s_data/s_tlast upstream;
//        m_valid/m_ready/m_data/m_EOL/m_tlast to core; frame_done pulse; busy;
//        err_early_tlast / err_late_tlast sticky framing errors.
// Build option: define FRAME_CHECK_EN to compare s_tlast with the counter framing;
// without it s_tlast is ignored and both error flags are tied low.
module pixel_stream_tagger
  import pixel_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int COL_W      = 6,
  parameter int ROW_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_tlast,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_EOL,
  output logic                  m_tlast,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  err_early_tlast,
  output logic                  err_late_tlast
);

  // Same layout as the package beat_t, sized by this instance's DATA_WIDTH.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  eol;
    logic                  tlast;
  } tag_beat_t;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  if (COL_W < clog2(IMG_WIDTH) || IMG_WIDTH < 2) begin : g_col_chk
    $error("pixel_stream_tagger: IMG_WIDTH must be >= 2 and fit in COL_W");
  end
  if (ROW_W < clog2(IMG_HEIGHT) || IMG_HEIGHT < 1) begin : g_row_chk
    $error("pixel_stream_tagger: IMG_HEIGHT must be >= 1 and fit in ROW_W");
  end

  state_t           state;
  state_t           state_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             i_hs;
  logic             o_hs;
  logic             at_eol;
  logic             at_last;
  logic             early;
  logic             beat_eol;
  logic             beat_tlast;
  logic             skid_full;
  tag_beat_t        in_beat;
  tag_beat_t        out_beat;

  assign i_hs    = s_valid & s_ready;
  assign o_hs    = m_valid & m_ready;
  assign at_eol  = (col == COL_LAST);
  assign at_last = at_eol & (row == ROW_LAST);

`ifdef FRAME_CHECK_EN
  logic err_early_q;
  logic err_late_q;

  // An upstream end-of-frame ahead of the counters truncates the frame here.
  assign early = s_tlast & ~at_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_early_q <= 1'b0;
      err_late_q  <= 1'b0;
    end else if (i_hs) begin
      if (early) begin
        err_early_q <= 1'b1;
      end
      if (at_last && !s_tlast) begin
        err_late_q <= 1'b1;
      end
    end
  end

  assign err_early_tlast = err_early_q;
  assign err_late_tlast  = err_late_q;
`else
  logic unused_s_tlast;

  assign unused_s_tlast  = s_tlast;
  assign early           = 1'b0;
  assign err_early_tlast = 1'b0;
  assign err_late_tlast  = 1'b0;
`endif

  assign beat_eol   = at_eol | early;
  assign beat_tlast = at_last | early;

  // Counters advance per accepted pixel; any tlast beat (counted or early) resyncs to 0/0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (i_hs) begin
      if (beat_tlast) begin
        col <= '0;
        row <= '0;
      end else if (at_eol) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A single-beat (early-truncated) frame never leaves IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_hs && !beat_tlast) state_nxt = ACTIVE;
      ACTIVE:  if (i_hs && beat_tlast)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_beat.data  = s_data;
  assign in_beat.eol   = beat_eol;
  assign in_beat.tlast = beat_tlast;

  stream_skid_buffer #(
    .WIDTH($bits(tag_beat_t))
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .up_vld    (s_valid),
    .up_rdy    (s_ready),
    .up_dat    (in_beat),
    .dn_vld    (m_valid),
    .dn_rdy    (m_ready),
    .dn_dat    (out_beat),
    .skid_full (skid_full)
  );

  assign m_data  = out_beat.data;
  assign m_EOL   = out_beat.eol;
  assign m_tlast = out_beat.tlast;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= o_hs & out_beat.tlast;
    end
  end

  assign busy = (state == ACTIVE) | m_valid | skid_full;

endmodule

// File: tb/tb_pixel_stream_tagger.sv
// Scoreboard bench for pixel_stream_tagger on a 4x2 image.
// Inputs change on the falling edge; DUT outputs are sampled just before the rising edge.
module tb_pixel_stream_tagger;
  import pixel_stream_pkg::*;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_tlast = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_EOL;
  logic          m_tlast;
  logic          frame_done;
  logic          busy;
  logic          err_early_tlast;
  logic          err_late_tlast;

  pixel_stream_tagger #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .COL_W      (2),
    .ROW_W      (1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .s_tlast         (s_tlast),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_EOL           (m_EOL),
    .m_tlast         (m_tlast),
    .frame_done      (frame_done),
    .busy            (busy),
    .err_early_tlast (err_early_tlast),
    .err_late_tlast  (err_late_tlast)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    beat_t b;
    logic  sent_tlast;
    int    acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mcol = 0;
  int   mrow = 0;
  logic exp_early = 1'b0;
  logic exp_late = 1'b0;
  logic exp_fd = 1'b0;
  bit   check_lat = 1'b0;
  int   fd_count = 0;
  int   stalls = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Reference tagging for one accepted pixel.
  task automatic accept(input logic [DW-1:0] d, input logic tl);
    exp_t e;
    logic eol;
    logic last;
    eol  = (mcol == W - 1);
    last = eol && (mrow == H - 1);
`ifdef FRAME_CHECK_EN
    if (tl && !last) begin
      eol       = 1'b1;
      last      = 1'b1;
      exp_early = 1'b1;
    end else if (last && !tl) begin
      exp_late = 1'b1;
    end
`endif
    e.b.data     = d;
    e.b.eol      = eol;
    e.b.tlast    = last;
    e.sent_tlast = tl;
    e.acc        = cyc;
    exp_q.push_back(e);
    if (last) begin
      mcol = 0;
      mrow = 0;
    end else if (eol) begin
      mcol = 0;
      mrow++;
    end else begin
      mcol++;
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic tl);
    int waitc;
    waitc = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_tlast = tl;
    #3;
    while (!s_ready) begin
      // Ready may only drop once main and skid both hold a beat.
      chk("sready_depth", exp_q.size(), 2);
      stalls++;
      waitc++;
      if (waitc > 50) begin
        chk("sready_wait_bound", waitc, 50);
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #3;
    end
    accept(d, tl);
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input int n, input int tl_idx);
    for (int i = 0; i < n; i++) begin
      send(base + DW'(i), (i == tl_idx));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(negedge clk);
    #4;
    chk("busy_after", 32'(busy), 0);
  endtask

  // Output monitor: pops the scoreboard on every output handshake.
  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      exp_fd = 1'b0;
    end else begin
      if (exp_fd || frame_done) chk("frame_done", 32'(frame_done), 32'(exp_fd));
      if (frame_done) fd_count++;
      exp_fd = 1'b0;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", 32'(exp_q.size() != 0), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("m_data", 32'(m_data), 32'(e.b.data));
          chk("m_EOL", 32'(m_EOL), 32'(e.b.eol));
          chk("m_tlast", 32'(m_tlast), 32'(e.b.tlast));
          if (check_lat) chk("latency", cyc - e.acc, 1);
          exp_fd = e.b.tlast;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #2;
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_EOL", 32'(m_EOL), 0);
    chk("rst_m_tlast", 32'(m_tlast), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err_early", 32'(err_early_tlast), 0);
    chk("rst_err_late", 32'(err_late_tlast), 0);
    chk("post_rst_s_ready", 32'(s_ready), 1);

    // 1: single frame, full throughput
    check_lat = 1'b1;
    fd_count  = 0;
    send_frame(8'h10, 8, 7);
    idle();
    drain();
    chk("t1_frames", fd_count, 1);
    check_lat = 1'b0;

    // 2: downstream stall for four cycles mid-frame
    fd_count = 0;
    stalls   = 0;
    fork
      send_frame(8'h10, 8, 7);
      begin
        repeat (2) @(negedge clk);
        m_ready = 1'b0;
        repeat (4) @(negedge clk);
        m_ready = 1'b1;
      end
    join
    idle();
    drain();
    chk("t2_stall_seen", 32'(stalls != 0), 1);
    chk("t2_frames", fd_count, 1);

    // 3: two frames back to back, no bubbles
    check_lat = 1'b1;
    fd_count  = 0;
    stalls    = 0;
    send_frame(8'h80, 8, 7);
    send_frame(8'h88, 8, 7);
    idle();
    drain();
    chk("t3_frames", fd_count, 2);
    chk("t3_no_stall", stalls, 0);
    check_lat = 1'b0;
    chk("t3_err_early", 32'(err_early_tlast), 32'(exp_early));
    chk("t3_err_late", 32'(err_late_tlast), 32'(exp_late));

    // 4: reset after three accepted beats, then a fresh frame
    fd_count = 0;
    send_frame(8'h30, 3, -1);
    @(negedge clk);
    s_valid = 1'b0;
    #2;
    chk("t4_busy_mid", 32'(busy), 1);
    rst_n = 1'b0;
    exp_q.delete();
    mcol = 0;
    mrow = 0;
    #1;
    chk("t4_sready_rst", 32'(s_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("t4_m_valid", 32'(m_valid), 0);
    chk("t4_busy", 32'(busy), 0);
    send_frame(8'h40, 8, 7);
    idle();
    drain();
    chk("t4_frames", fd_count, 1);

`ifdef FRAME_CHECK_EN
    // 5: s_tlast on the 5th pixel truncates the frame
    fd_count = 0;
    send_frame(8'h50, 5, 4);
    send_frame(8'h55, 8, 7);
    idle();
    drain();
    chk("t5_err_early", 32'(err_early_tlast), 1);
    chk("t5_err_late", 32'(err_late_tlast), 0);
    chk("t5_frames", fd_count, 2);

    // 6: frame end with no s_tlast
    fd_count = 0;
    send_frame(8'h60, 7, -1);
    chk("t6_err_late_pre", 32'(err_late_tlast), 0);
    send(8'h67, 1'b0);
    idle();
    #2;
    chk("t6_err_late", 32'(err_late_tlast), 1);
    drain();
    chk("t6_frames", fd_count, 1);
`endif

    chk("end_err_early", 32'(err_early_tlast), 32'(exp_early));
    chk("end_err_late", 32'(err_late_tlast), 32'(exp_late));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
